// File: rtl/online_iir_pole_mc.sv
// -----------------------------------------------------------------------------
// online_iir_pole_mc
//
// Multi-channel, time-multiplexed pole section of the online IIR chain.
// For every accepted sample on channel c it produces
//    y = x*2^CSHIFT + C1*x[n-D1] + C2*x[n-D2]
// on redundant (plus/minus digit) operands.  With bypass high the two taps
// are dropped and y = x*2^CSHIFT; the history still shifts in either case.
//
// Digit format: digit i lives at bits [2i+1:2i] as {plus,minus}; value is
// plus-minus, so {1,1} decodes as 0.
//
// Ports
//    clk       clock
//    rst       synchronous active-high reset (beats clear and in_valid)
//    clear     zero every channel history at this edge (in_ch_o kept)
//    bypass    sampled with in_valid; drop the feedback taps
//    in_valid  din_x carries a sample for channel in_ch_o
//    din_x     redundant input sample, STAGE digits
//    in_ch_o   channel the next accepted sample belongs to
//    out_valid data_out / out_ch are meaningful this cycle
//    out_ch    channel of data_out
//    data_out  redundant result, OSTAGE digits
//
// Handshake: there is no backpressure.  A sample is taken on every cycle
// in_valid is high; its result shows up with out_valid high exactly one cycle
// later, and out_valid is low on any cycle following an idle (in_valid=0)
// cycle.  out_ch / data_out hold their last value while out_valid is low.
// -----------------------------------------------------------------------------
module online_iir_pole_mc #(
   parameter int STAGE    = 8,
   parameter int CHANNELS = 2,
   parameter int D1       = 2,
   parameter int D2       = 4,
   parameter int DEPTH    = 4,
   parameter int C1       = 117,
   parameter int C2       = 24,
   parameter int COEF_W   = 7,
   parameter int CSHIFT   = 7,
   parameter int OSTAGE   = STAGE + COEF_W + 2,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  bypass,
   input  logic                  in_valid,
   input  logic [2*STAGE-1:0]    din_x,
   output logic [CH_W-1:0]       in_ch_o,
   output logic                  out_valid,
   output logic [CH_W-1:0]       out_ch,
   output logic [2*OSTAGE-1:0]   data_out
);

   localparam int                WL      = 2 * STAGE;
   localparam logic [OSTAGE-1:0] C1_E    = OSTAGE'(C1);
   localparam logic [OSTAGE-1:0] C2_E    = OSTAGE'(C2);
   localparam logic [CH_W-1:0]   CH_LAST = CH_W'(CHANNELS - 1);

   logic [WL-1:0]       r_hist [CHANNELS][DEPTH];
   logic [CH_W-1:0]     r_ch;
   logic                r_valid;
   logic [CH_W-1:0]     r_och;
   logic [2*OSTAGE-1:0] r_data;

   logic [WL-1:0]       w_tap1;
   logic [WL-1:0]       w_tap2;
   logic [STAGE-1:0]    w_p_x, w_m_x;
   logic [STAGE-1:0]    w_p_t1, w_m_t1;
   logic [STAGE-1:0]    w_p_t2, w_m_t2;
   logic [OSTAGE-1:0]   w_sum_p, w_sum_m;
   logic [2*OSTAGE-1:0] w_data;

   // Taps read the pre-shift history. A same-cycle clear means the sample
   // sees zero history; bypass simply drops both taps.
   always_comb begin
      w_tap1 = r_hist[r_ch][D1-1];
      w_tap2 = r_hist[r_ch][D2-1];
      if (clear || bypass) begin
         w_tap1 = '0;
         w_tap2 = '0;
      end
   end

   // Split each redundant word into its plus and minus magnitude vectors.
   always_comb begin
      w_p_x  = '0;
      w_m_x  = '0;
      w_p_t1 = '0;
      w_m_t1 = '0;
      w_p_t2 = '0;
      w_m_t2 = '0;
      for (int i = 0; i < STAGE; i++) begin
         w_p_x[i]  = din_x[2*i+1];
         w_m_x[i]  = din_x[2*i];
         w_p_t1[i] = w_tap1[2*i+1];
         w_m_t1[i] = w_tap1[2*i];
         w_p_t2[i] = w_tap2[2*i+1];
         w_m_t2[i] = w_tap2[2*i];
      end
   end

   // The filter is linear with nonnegative coefficients, so the plus and
   // minus halves are filtered independently; y = sum_p - sum_m.  Each half
   // is bounded by (2^CSHIFT + C1 + C2) * (2^STAGE - 1) < 2^OSTAGE, so the
   // unsigned sums never wrap.
   always_comb begin
      w_sum_p = (OSTAGE'(w_p_x) << CSHIFT) + C1_E * OSTAGE'(w_p_t1)
              + C2_E * OSTAGE'(w_p_t2);
      w_sum_m = (OSTAGE'(w_m_x) << CSHIFT) + C1_E * OSTAGE'(w_m_t1)
              + C2_E * OSTAGE'(w_m_t2);
      w_data  = '0;
      for (int i = 0; i < OSTAGE; i++) begin
         w_data[2*i+1] = w_sum_p[i];
         w_data[2*i]   = w_sum_m[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_och   <= '0;
         r_data  <= '0;
         r_ch    <= '0;
         for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < DEPTH; k++)
               r_hist[c][k] <= '0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_och  <= r_ch;
            r_data <= w_data;
            r_ch   <= (r_ch == CH_LAST) ? '0 : r_ch + CH_W'(1);
         end
         if (clear)
            for (int c = 0; c < CHANNELS; c++)
               for (int k = 0; k < DEPTH; k++)
                  r_hist[c][k] <= '0;
         // Later assignments win: with clear and in_valid together the
         // channel ends up holding only the new sample at index 0.
         if (in_valid) begin
            for (int k = DEPTH - 1; k > 0; k--)
               r_hist[r_ch][k] <= clear ? '0 : r_hist[r_ch][k-1];
            r_hist[r_ch][0] <= din_x;
         end
      end
   end

   assign in_ch_o   = r_ch;
   assign out_valid = r_valid;
   assign out_ch    = r_och;
   assign data_out  = r_data;

endmodule

// File: tb/tb_online_iir_pole_mc.sv
module tb_online_iir_pole_mc;

   localparam int STAGE    = 8;
   localparam int CHANNELS = 2;
   localparam int D1       = 2;
   localparam int D2       = 4;
   localparam int DEPTH    = 4;
   localparam int C1       = 117;
   localparam int C2       = 24;
   localparam int COEF_W   = 7;
   localparam int CSHIFT   = 7;
   localparam int OSTAGE   = STAGE + COEF_W + 2;
   localparam int CH_W     = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst = 1'b1;
   logic                clear = 1'b0;
   logic                bypass = 1'b0;
   logic                in_valid = 1'b0;
   logic [2*STAGE-1:0]  din_x = '0;
   logic [CH_W-1:0]     in_ch_o;
   logic                out_valid;
   logic [CH_W-1:0]     out_ch;
   logic [2*OSTAGE-1:0] data_out;

   online_iir_pole_mc #(
      .STAGE(STAGE), .CHANNELS(CHANNELS), .D1(D1), .D2(D2), .DEPTH(DEPTH),
      .C1(C1), .C2(C2), .COEF_W(COEF_W), .CSHIFT(CSHIFT), .OSTAGE(OSTAGE)
   ) dut (
      .clk(clk), .rst(rst), .clear(clear), .bypass(bypass),
      .in_valid(in_valid), .din_x(din_x), .in_ch_o(in_ch_o),
      .out_valid(out_valid), .out_ch(out_ch), .data_out(data_out)
   );

   // ---------------- counters / helpers ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*STAGE-1:0] mk(input int p, input int m);
      logic [2*STAGE-1:0] r;
      r = '0;
      for (int i = 0; i < STAGE; i++) begin
         r[2*i+1] = p[i];
         r[2*i]   = m[i];
      end
      return r;
   endfunction

   // Random redundant encoding of v (|v| <= 255): choose a minus part, plus
   // part follows, shared bits give {1,1} digits.
   function automatic logic [2*STAGE-1:0] enc_rand(input int v);
      int lo, hi, m;
      lo = (v < 0) ? -v : 0;
      hi = (v >= 0) ? 255 - v : 255;
      m  = int'($urandom_range(hi, lo));
      return mk(v + m, m);
   endfunction

   function automatic int dec(input logic [2*OSTAGE-1:0] w);
      int v;
      v = 0;
      for (int i = 0; i < OSTAGE; i++)
         v += (int'(w[2*i+1]) - int'(w[2*i])) * (1 << i);
      return v;
   endfunction

   // ---------------- behavioural model ----------------
   // Per channel: list of past sample values, newest first.
   int mh [CHANNELS][DEPTH];
   int mch = 0;

   // exp entry: [41] after reset, [40] valid, [39:36] ch, [35:32] in_ch, [31:0] y
   logic [41:0] exp_q[$];

   task automatic model(input logic r, c, b, v, input int x, output int y);
      logic [41:0] e;
      int ch;
      y  = 0;
      ch = mch;
      if (r) begin
         foreach (mh[i, k]) mh[i][k] = 0;
         mch = 0;
         e = {1'b1, 1'b0, 4'd0, 4'd0, 32'd0};
      end else begin
         if (c) foreach (mh[i, k]) mh[i][k] = 0;
         if (v) begin
            y = x * (1 << CSHIFT);
            if (!b) y += C1 * mh[ch][D1-1] + C2 * mh[ch][D2-1];
            for (int k = DEPTH - 1; k > 0; k--) mh[ch][k] = mh[ch][k-1];
            mh[ch][0] = x;
            mch = (ch + 1) % CHANNELS;
         end
         e = {1'b0, v, 4'(ch), 4'(mch), 32'(y)};
      end
      exp_q.push_back(e);
   endtask

   // ---------------- driver ----------------
   task automatic drive_raw(input logic r, c, b, v, input logic [2*STAGE-1:0] raw,
                            input int x, output int y);
      @(negedge clk);
      rst = r; clear = c; bypass = b; in_valid = v; din_x = raw;
      model(r, c, b, v, x, y);
   endtask

   task automatic drive(input logic r, c, b, v, input int x, output int y);
      drive_raw(r, c, b, v, enc_rand(x), x, y);
   endtask

   // ---------------- scoreboard / compare process ----------------
   initial begin
      logic [41:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("in_ch_o", int'(in_ch_o), int'(e[35:32]));
            chk("out_valid", int'(out_valid), int'(e[40]));
            if (e[41]) begin
               chk("rst_out_ch", int'(out_ch), 0);
               chk("rst_data", dec(data_out), 0);
               chk("rst_raw", int'(data_out != '0), 0);
            end
            if (e[40]) begin
               chk("out_ch", int'(out_ch), int'(e[39:36]));
               chk("data_out", dec(data_out), int'(signed'(e[31:0])));
            end
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   int y;
   int lit_q[$];

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 0, y);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 0, y);
   endtask

   // Impulse on ch0 then zeros; ch0 results collected into lit_q.
   // With gap set, two idle cycles follow every pair of accepted samples.
   task automatic impulse(input bit gap, input int n);
      int yy;
      lit_q.delete();
      for (int s = 0; s < n; s++) begin
         drive_raw(1'b0, 1'b0, 1'b0, 1'b1, (s == 0) ? mk(1, 0) : mk(0, 0),
                   (s == 0) ? 1 : 0, yy);
         lit_q.push_back(yy);
         drive(1'b0, 1'b0, 1'b0, 1'b1, 0, yy);
         chk("ch1_zero", yy, 0);
         if (gap) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 0, yy);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 0, yy);
         end
      end
   endtask

   task automatic chk_impulse(input string name, input int n);
      int ref_v[6];
      ref_v = '{128, 0, 117, 0, 24, 0};
      for (int i = 0; i < n; i++) chk(name, lit_q[i], ref_v[i]);
   endtask

   initial begin
      int y0, y1, y2;
      do_reset();

      // impulse response
      impulse(1'b0, 6);
      chk_impulse("impulse", 6);

      // negative / mixed redundant digits
      do_reset();
      drive_raw(1'b0, 1'b0, 1'b0, 1'b1, mk(7, 10), -3, y0);    // {1,1} on digit 1
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive_raw(1'b0, 1'b0, 1'b0, 1'b1, mk(13, 8), 5, y2);     // {1,1} on digit 3
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      chk("neg_n0", y0, -384);
      chk("neg_n1", y1, 0);
      chk("neg_n2", y2, 289);

      // gapped impulse
      do_reset();
      impulse(1'b1, 6);
      chk_impulse("gapped", 6);

      // clear coincident with ch0 sample at n=2
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1, y);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3, y0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y2);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      chk("clr_n2", y0, 384);
      chk("clr_n3", y1, 0);
      chk("clr_n4", y2, 351);

      // bypass on ch1 with nonzero history
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 5, y);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 7, y0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, y2);
      chk("byp_n2", y0, 896);
      chk("byp_n3", y1, 0);
      chk("byp_n4", y2, 939);

      // reset mid-stream with in_valid and clear high, then fresh impulse
      drive(1'b0, 1'b0, 1'b0, 1'b1, 9, y);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 9, y);
      impulse(1'b0, 5);
      chk_impulse("post_rst", 5);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(99, 0) < 1),
               ($urandom_range(99, 0) < 3),
               ($urandom_range(99, 0) < 10),
               ($urandom_range(99, 0) < 70),
               int'($urandom_range(510, 0)) - 255, y);
      end

      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, y);
      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
